// File: rtl/ahb_lite_slave_controller.sv
// ---------------------------------------------------------------------------
// ahb_lite_slave_controller
//
// Purpose:
//   AHB-Lite slave front end. It accepts address phases from the bus, latches
//   the transfer attributes for a backend, and then runs the data phase. The
//   data phase is either a backend access (with wait states) or the standard
//   two-cycle AHB ERROR response.
//
// Optional feature:
//   AHB_SLAVE_TIMEOUT_EN - when defined, a watchdog bounds the wait states
//   spent in ACCESS to TIMEOUT_CYCLES cycles. A transfer that runs out of time
//   ends with an ERROR response. When it is undefined, ACCESS waits for be_ack
//   indefinitely and no counter is built.
//
// Ports:
//   HCLK, HRESETn  clock; asynchronous active-low reset
//   HSELx          slave select
//   HADDR[31:0]    address-phase address
//   HWRITE         address-phase direction (1 = write)
//   HSIZE[2:0]     address-phase transfer size
//   HTRANS[1:0]    IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
//   HREADY         bus-level ready (previous data phase done)
//   HREADYOUT      slave ready for the current data phase
//   HRESP          slave response (1 = ERROR)
//   be_req         backend request, high exactly while in ACCESS
//   be_write       latched HWRITE
//   be_addr[31:0]  latched HADDR
//   be_size[2:0]   latched HSIZE
//   be_ack         backend completes the access this cycle
//   be_err         backend error, meaningful only together with be_ack
//   fsm_state[1:0] current state (IDLE=0, ACCESS=1, ERR1=2, ERR2=3), debug only
//
// Backend handshake:
//   be_req behaves as a valid and be_ack as a ready. The request and the
//   be_write/be_addr/be_size attributes stay stable from the first ACCESS cycle
//   until the cycle in which be_ack is sampled high. That cycle ends the
//   access, and be_err is only looked at in that cycle. be_ack and be_err are
//   ignored in every other state.
// ---------------------------------------------------------------------------
module ahb_lite_slave_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSELx,
  input  logic [31:0] HADDR,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [1:0]  HTRANS,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic        be_req,
  output logic        be_write,
  output logic [31:0] be_addr,
  output logic [2:0]  be_size,
  input  logic        be_ack,
  input  logic        be_err,
  output logic [1:0]  fsm_state
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_ERR1   = 2'd2;
  localparam logic [1:0] ST_ERR2   = 2'd3;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       accept;
  logic       illegal;
  logic       take;
  logic       timeout;
  logic       unused_htrans_lsb;

  // Only HTRANS[1] separates NONSEQ/SEQ from IDLE/BUSY.
  assign accept            = HSELx & HTRANS[1] & HREADY;
  assign unused_htrans_lsb = HTRANS[0];

  // Sizes above a word are not supported. Halfword and word transfers must be
  // naturally aligned.
  always_comb begin
    illegal = 1'b0;
    case (HSIZE)
      3'd0:    illegal = 1'b0;
      3'd1:    illegal = HADDR[0];
      3'd2:    illegal = |HADDR[1:0];
      default: illegal = 1'b1;
    endcase
  end

  // take marks the cycles in which the FSM may start a new transfer: IDLE,
  // the successful last cycle of ACCESS, and ERR2. In all three cycles
  // HREADYOUT is 1, so the address phase on the bus really belongs to us.
  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    case (state)
      ST_IDLE: begin
        take = accept;
      end
      ST_ACCESS: begin
        if (be_ack) begin
          if (be_err) begin
            state_nxt = ST_ERR1;
          end else begin
            state_nxt = ST_IDLE;
            take      = accept;
          end
        end else if (timeout) begin
          state_nxt = ST_ERR1;
        end
      end
      ST_ERR1: begin
        state_nxt = ST_ERR2;
      end
      ST_ERR2: begin
        state_nxt = ST_IDLE;
        take      = accept;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
    if (take) begin
      state_nxt = illegal ? ST_ERR1 : ST_ACCESS;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // The attributes are latched on every accept, including illegal ones, so
  // be_addr always shows the transfer currently in its data phase.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      be_write <= 1'b0;
      be_addr  <= '0;
      be_size  <= '0;
    end else if (take) begin
      be_write <= HWRITE;
      be_addr  <= HADDR;
      be_size  <= HSIZE;
    end
  end

`ifdef AHB_SLAVE_TIMEOUT_EN
  // The wait counter counts ACCESS cycles without be_ack. It only has to
  // reach TIMEOUT_CYCLES-1, because leaving ACCESS stops it there.
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] WAIT_LIMIT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] wait_cnt;

  // Every entry into ACCESS goes through take, so clearing on take also
  // restarts the count for back-to-back transfers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wait_cnt <= '0;
    end else if (take) begin
      wait_cnt <= '0;
    end else if ((state == ST_ACCESS) && !be_ack) begin
      wait_cnt <= wait_cnt + CW'(1);
    end
  end

  assign timeout = (state == ST_ACCESS) && !be_ack && (wait_cnt == WAIT_LIMIT);
`else
  assign timeout = 1'b0;

  // TIMEOUT_CYCLES stays part of the interface in every build. Here it is
  // only referenced, and nothing is generated from it.
  if (TIMEOUT_CYCLES == 0) begin : g_no_watchdog
  end
`endif

  // All outputs are decoded from the state register. The only exception is
  // HREADYOUT in ACCESS, which must follow be_ack in the same cycle.
  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    case (state)
      ST_IDLE: begin
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
      end
      ST_ACCESS: begin
        HREADYOUT = be_ack & ~be_err;
        HRESP     = 1'b0;
      end
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
      end
      ST_ERR2: begin
        HREADYOUT = 1'b1;
        HRESP     = 1'b1;
      end
      default: begin
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
      end
    endcase
  end

  assign be_req    = (state == ST_ACCESS);
  assign fsm_state = state;

endmodule

// File: tb/tb_ahb_lite_slave_controller.sv
// ---------------------------------------------------------------------------
// tb_ahb_lite_slave_controller
//
// Bench for ahb_lite_slave_controller. HREADY is looped back from HREADYOUT,
// the way a single-slave bus would drive it. hready_block can force HREADY
// low to show that an address phase is then ignored. Inputs change 1 ns after
// the rising edge, and outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_ahb_lite_slave_controller;

  logic        HCLK;
  logic        HRESETn;
  logic        HSELx;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [1:0]  HTRANS;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic        be_req;
  logic        be_write;
  logic [31:0] be_addr;
  logic [2:0]  be_size;
  logic        be_ack;
  logic        be_err;
  logic [1:0]  fsm_state;
  logic        hready_block;

  int checks = 0;
  int errors = 0;

  // Model of the latched backend attributes, updated from the bench's own
  // knowledge of which cycles carry an accepted address phase.
  logic [31:0] m_addr;
  logic        m_write;
  logic [2:0]  m_size;

  assign HREADY = HREADYOUT & ~hready_block;

  ahb_lite_slave_controller #(.TIMEOUT_CYCLES(4)) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .HSELx     (HSELx),
    .HADDR     (HADDR),
    .HWRITE    (HWRITE),
    .HSIZE     (HSIZE),
    .HTRANS    (HTRANS),
    .HREADY    (HREADY),
    .HREADYOUT (HREADYOUT),
    .HRESP     (HRESP),
    .be_req    (be_req),
    .be_write  (be_write),
    .be_addr   (be_addr),
    .be_size   (be_size),
    .be_ack    (be_ack),
    .be_err    (be_err),
    .fsm_state (fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, run did not complete");
    $fatal(1, "time limit");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic drive(input logic sel, input logic [1:0] trans, input logic [31:0] addr,
                       input logic wr, input logic [2:0] size, input logic ack, input logic err);
    HSELx  = sel;
    HTRANS = trans;
    HADDR  = addr;
    HWRITE = wr;
    HSIZE  = size;
    be_ack = ack;
    be_err = err;
  endtask

  task automatic idle();
    drive(1'b0, 2'b00, 32'h0, 1'b0, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Waits for the sampling point, then checks the three bus-facing outputs.
  task automatic chk_bus(input string name, input logic rdy, input logic rsp, input logic req);
    @(negedge HCLK);
    chk({name, "_hreadyout"}, {31'b0, HREADYOUT}, {31'b0, rdy});
    chk({name, "_hresp"},     {31'b0, HRESP},     {31'b0, rsp});
    chk({name, "_be_req"},    {31'b0, be_req},    {31'b0, req});
  endtask

  task automatic reset_pulse();
    idle();
    HRESETn = 1'b0;
    #2;
    HRESETn = 1'b1;
    m_addr  = 32'h0;
    m_write = 1'b0;
    m_size  = 3'd0;
    tick();
  endtask

  // ---------------- table-driven vectors ----------------
  typedef struct {
    string       name;
    logic        sel;
    logic [1:0]  trans;
    logic [2:0]  size;
    logic [31:0] addr;
    logic        block;
    logic        exp_req;
    logic        exp_err;
  } vec_t;

  vec_t vecs[13];

  // ---------------- random schedule ----------------
  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic [31:0] addr;
    logic        write;
    logic [2:0]  size;
    logic        ack;
    logic        err;
    logic        acc;
    logic        exp_ready;
    logic        exp_resp;
    logic        exp_req;
  } cyc_t;

  cyc_t sched[$];

  // A cycle with random bus noise. When the slave is ready, the noise must
  // not form an accepted address phase. When it is not ready, anything goes.
  function automatic cyc_t noise_cycle(input logic rdy, input logic rsp, input logic req);
    cyc_t c;
    c.sel   = 1'($urandom_range(0, 1));
    c.trans = 2'($urandom_range(0, 3));
    if (rdy && c.sel) c.trans[1] = 1'b0;
    c.addr      = $urandom;
    c.write     = 1'($urandom_range(0, 1));
    c.size      = 3'($urandom_range(0, 7));
    c.ack       = 1'($urandom_range(0, 1));
    c.err       = 1'($urandom_range(0, 1));
    c.acc       = 1'b0;
    c.exp_ready = rdy;
    c.exp_resp  = rsp;
    c.exp_req   = req;
    return c;
  endfunction

  task automatic build_schedule(input int n_xfer);
    cyc_t c;
    int   gap;
    int   dly;
    logic e;
    logic bad;
    sched.delete();
    sched.push_back(noise_cycle(1'b1, 1'b0, 1'b0));
    for (int t = 0; t < n_xfer; t++) begin
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) sched.push_back(noise_cycle(1'b1, 1'b0, 1'b0));
      // The address phase sits on the last scheduled cycle, which is always
      // one where the slave is ready.
      c = sched.pop_back();
      c.sel   = 1'b1;
      c.trans = ($urandom_range(0, 1) == 0) ? 2'b10 : 2'b11;
      c.write = 1'($urandom_range(0, 1));
      c.size  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      c.addr  = $urandom;
      if ($urandom_range(0, 3) != 0) c.addr[1:0] = 2'b00;
      c.acc   = 1'b1;
      sched.push_back(c);
      // A transfer is bad if it is wider than a word or not aligned to its own size.
      bad = (c.size > 3'd2) || ((c.addr % (32'd1 << c.size)) != 0);
      if (bad) begin
        sched.push_back(noise_cycle(1'b0, 1'b1, 1'b0));
        sched.push_back(noise_cycle(1'b1, 1'b1, 1'b0));
      end else begin
        dly = $urandom_range(0, 3);
        for (int k = 0; k < dly; k++) begin
          c = noise_cycle(1'b0, 1'b0, 1'b1);
          c.ack = 1'b0;
          sched.push_back(c);
        end
        e = ($urandom_range(0, 3) == 0);
        c = noise_cycle(!e, 1'b0, 1'b1);
        c.ack = 1'b1;
        c.err = e;
        sched.push_back(c);
        if (e) begin
          sched.push_back(noise_cycle(1'b0, 1'b1, 1'b0));
          sched.push_back(noise_cycle(1'b1, 1'b1, 1'b0));
        end
      end
    end
    sched.push_back(noise_cycle(1'b1, 1'b0, 1'b0));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    cyc_t c;
    logic acc;
    hready_block = 1'b0;
    HRESETn      = 1'b0;
    idle();

    // Reset state
    #12;
    chk("rst_hreadyout", {31'b0, HREADYOUT}, 32'd1);
    chk("rst_hresp",     {31'b0, HRESP},     32'd0);
    chk("rst_be_req",    {31'b0, be_req},    32'd0);
    chk("rst_be_write",  {31'b0, be_write},  32'd0);
    chk("rst_be_addr",   be_addr,            32'd0);
    chk("rst_be_size",   {29'b0, be_size},   32'd0);
    #10;
    HRESETn = 1'b1;
    tick();

    // Write with two wait states
    drive(1'b1, 2'b10, 32'h100, 1'b1, 3'd2, 1'b0, 1'b0);
    chk_bus("wr_c0", 1'b1, 1'b0, 1'b0);
    tick();
    idle();
    chk_bus("wr_c1", 1'b0, 1'b0, 1'b1);
    chk("wr_be_addr",  be_addr, 32'h100);
    chk("wr_be_write", {31'b0, be_write}, 32'd1);
    chk("wr_be_size",  {29'b0, be_size}, 32'd2);
    tick();
    chk_bus("wr_c2", 1'b0, 1'b0, 1'b1);
    tick();
    drive(1'b0, 2'b00, 32'h0, 1'b0, 3'd0, 1'b1, 1'b0);
    chk_bus("wr_c3", 1'b1, 1'b0, 1'b1);
    tick();
    idle();
    chk_bus("wr_c4", 1'b1, 1'b0, 1'b0);
    tick();

    // Misaligned word: error response, no backend request
    drive(1'b1, 2'b10, 32'h102, 1'b0, 3'd2, 1'b0, 1'b0);
    chk_bus("mis_c0", 1'b1, 1'b0, 1'b0);
    tick();
    idle();
    chk_bus("mis_c1", 1'b0, 1'b1, 1'b0);
    chk("mis_be_addr", be_addr, 32'h102);
    tick();
    chk_bus("mis_c2", 1'b1, 1'b1, 1'b0);
    tick();
    chk_bus("mis_c3", 1'b1, 1'b0, 1'b0);
    tick();

    // Back-to-back reads with an immediate ack
    drive(1'b1, 2'b10, 32'h0, 1'b0, 3'd2, 1'b0, 1'b0);
    chk_bus("b2b_c0", 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 2'b10, 32'h4, 1'b0, 3'd2, 1'b1, 1'b0);
    chk_bus("b2b_c1", 1'b1, 1'b0, 1'b1);
    chk("b2b_addr0", be_addr, 32'h0);
    tick();
    drive(1'b0, 2'b00, 32'h0, 1'b0, 3'd0, 1'b1, 1'b0);
    chk_bus("b2b_c2", 1'b1, 1'b0, 1'b1);
    chk("b2b_addr1", be_addr, 32'h4);
    tick();
    idle();
    chk_bus("b2b_c3", 1'b1, 1'b0, 1'b0);
    tick();

    // Backend error in the first ACCESS cycle; ack during ERR1 is ignored
    drive(1'b1, 2'b10, 32'h40, 1'b1, 3'd2, 1'b0, 1'b0);
    tick();
    drive(1'b0, 2'b00, 32'h0, 1'b0, 3'd0, 1'b1, 1'b1);
    chk_bus("berr_c1", 1'b0, 1'b0, 1'b1);
    tick();
    drive(1'b0, 2'b00, 32'h0, 1'b0, 3'd0, 1'b1, 1'b0);
    chk_bus("berr_c2", 1'b0, 1'b1, 1'b0);
    tick();
    idle();
    chk_bus("berr_c3", 1'b1, 1'b1, 1'b0);
    tick();
    chk_bus("berr_c4", 1'b1, 1'b0, 1'b0);
    tick();

    // Reset in the second ACCESS cycle, then a fresh accept
    drive(1'b1, 2'b10, 32'h300, 1'b1, 3'd2, 1'b0, 1'b0);
    tick();
    idle();
    tick();
    #2;
    HRESETn = 1'b0;
    #1;
    chk("arst_be_req",    {31'b0, be_req},    32'd0);
    chk("arst_hreadyout", {31'b0, HREADYOUT}, 32'd1);
    chk("arst_hresp",     {31'b0, HRESP},     32'd0);
    chk("arst_be_addr",   be_addr,            32'd0);
    @(negedge HCLK);
    #1;
    HRESETn = 1'b1;
    drive(1'b1, 2'b10, 32'h500, 1'b0, 3'd1, 1'b0, 1'b0);
    tick();
    drive(1'b0, 2'b00, 32'h0, 1'b0, 3'd0, 1'b1, 1'b0);
    chk_bus("arst_new", 1'b1, 1'b0, 1'b1);
    chk("arst_new_addr", be_addr, 32'h500);
    tick();
    idle();
    chk_bus("arst_idle", 1'b1, 1'b0, 1'b0);
    tick();

`ifdef AHB_SLAVE_TIMEOUT_EN
    // Watchdog expiry after four waiting ACCESS cycles
    drive(1'b1, 2'b10, 32'h80, 1'b0, 3'd2, 1'b0, 1'b0);
    tick();
    for (int k = 0; k < 4; k++) begin
      idle();
      chk_bus($sformatf("tmo_w%0d", k), 1'b0, 1'b0, 1'b1);
      tick();
    end
    drive(1'b0, 2'b00, 32'h0, 1'b0, 3'd0, 1'b1, 1'b0);
    chk_bus("tmo_err1", 1'b0, 1'b1, 1'b0);
    tick();
    idle();
    chk_bus("tmo_err2", 1'b1, 1'b1, 1'b0);
    tick();
    chk_bus("tmo_idle", 1'b1, 1'b0, 1'b0);
    tick();
`else
    // Without the watchdog a long wait keeps the request up
    drive(1'b1, 2'b10, 32'h80, 1'b0, 3'd2, 1'b0, 1'b0);
    tick();
    for (int k = 0; k < 12; k++) begin
      idle();
      chk_bus($sformatf("long_w%0d", k), 1'b0, 1'b0, 1'b1);
      tick();
    end
    drive(1'b0, 2'b00, 32'h0, 1'b0, 3'd0, 1'b1, 1'b0);
    chk_bus("long_done", 1'b1, 1'b0, 1'b1);
    tick();
    idle();
    chk_bus("long_idle", 1'b1, 1'b0, 1'b0);
    tick();
`endif

    // Table-driven address-phase decode, each vector starting from IDLE
    vecs[0]  = '{"htrans_idle",   1'b1, 2'b00, 3'd2, 32'h10,       1'b0, 1'b0, 1'b0};
    vecs[1]  = '{"htrans_busy",   1'b1, 2'b01, 3'd2, 32'h14,       1'b0, 1'b0, 1'b0};
    vecs[2]  = '{"not_selected",  1'b0, 2'b10, 3'd2, 32'h18,       1'b0, 1'b0, 1'b0};
    vecs[3]  = '{"byte_odd",      1'b1, 2'b10, 3'd0, 32'h13,       1'b0, 1'b1, 1'b0};
    vecs[4]  = '{"half_seq",      1'b1, 2'b11, 3'd1, 32'h22,       1'b0, 1'b1, 1'b0};
    vecs[5]  = '{"half_odd",      1'b1, 2'b10, 3'd1, 32'h21,       1'b0, 1'b0, 1'b1};
    vecs[6]  = '{"word_at_2",     1'b1, 2'b10, 3'd2, 32'h102,      1'b0, 1'b0, 1'b1};
    vecs[7]  = '{"word_at_1",     1'b1, 2'b11, 3'd2, 32'h101,      1'b0, 1'b0, 1'b1};
    vecs[8]  = '{"word_ok",       1'b1, 2'b10, 3'd2, 32'h104,      1'b0, 1'b1, 1'b0};
    vecs[9]  = '{"size_dword",    1'b1, 2'b10, 3'd3, 32'h0,        1'b0, 1'b0, 1'b1};
    vecs[10] = '{"size_7",        1'b1, 2'b11, 3'd7, 32'h8,        1'b0, 1'b0, 1'b1};
    vecs[11] = '{"hready_low",    1'b1, 2'b10, 3'd2, 32'h200,      1'b1, 1'b0, 1'b0};
    vecs[12] = '{"word_top",      1'b1, 2'b11, 3'd2, 32'hFFFFFFFC, 1'b0, 1'b1, 1'b0};

    reset_pulse();
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].sel, vecs[i].trans, vecs[i].addr, 1'(i % 2), vecs[i].size, 1'b0, 1'b0);
      hready_block = vecs[i].block;
      acc = vecs[i].exp_req | vecs[i].exp_err;
      chk_bus({"vec_", vecs[i].name, "_ap"}, 1'b1, 1'b0, 1'b0);
      tick();
      if (acc) begin
        m_addr  = vecs[i].addr;
        m_write = 1'(i % 2);
        m_size  = vecs[i].size;
      end
      idle();
      hready_block = 1'b0;
      chk_bus({"vec_", vecs[i].name, "_dp"}, ~vecs[i].exp_err & ~vecs[i].exp_req,
              vecs[i].exp_err, vecs[i].exp_req);
      chk({"vec_", vecs[i].name, "_addr"},  be_addr, m_addr);
      chk({"vec_", vecs[i].name, "_write"}, {31'b0, be_write}, {31'b0, m_write});
      chk({"vec_", vecs[i].name, "_size"},  {29'b0, be_size}, {29'b0, m_size});
      tick();
      if (vecs[i].exp_req) begin
        drive(1'b0, 2'b00, 32'h0, 1'b0, 3'd0, 1'b1, 1'b0);
        tick();
      end else if (vecs[i].exp_err) begin
        tick();
      end
      idle();
      chk_bus({"vec_", vecs[i].name, "_end"}, 1'b1, 1'b0, 1'b0);
      tick();
    end

    // Randomised transfer stream against the transaction-level schedule
    reset_pulse();
    build_schedule(60);
    for (int i = 0; i < sched.size(); i++) begin
      c = sched[i];
      drive(c.sel, c.trans, c.addr, c.write, c.size, c.ack, c.err);
      chk_bus($sformatf("rnd%0d", i), c.exp_ready, c.exp_resp, c.exp_req);
      chk($sformatf("rnd%0d_be_addr", i),  be_addr, m_addr);
      chk($sformatf("rnd%0d_be_write", i), {31'b0, be_write}, {31'b0, m_write});
      chk($sformatf("rnd%0d_be_size", i),  {29'b0, be_size}, {29'b0, m_size});
      if (c.acc) begin
        m_addr  = c.addr;
        m_write = c.write;
        m_size  = c.size;
      end
      tick();
    end

    // ---------------- final report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
